// File: rtl/stopwatch_ctrl.sv
// Button sequencer for the stop_watch counter: synchronises and debounces two
// push-buttons, runs the Idle/Run/Lap/Pause FSM and gates the count tick.
module stopwatch_ctrl #(
   parameter int unsigned DB_CYCLES = 20,
   parameter int unsigned TICK_DIV  = 100
) (
   input  logic       Clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   output logic       run,
   output logic       tick,
   output logic       clr,
   output logic       freeze,
   output logic [1:0] state
);

   localparam int unsigned DB_W   = $clog2(DB_CYCLES);
   localparam int unsigned TICK_W = $clog2(TICK_DIV);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_LAP   = 2'b10,
      S_PAUSE = 2'b11
   } state_t;

   // bit 0 = start/stop, bit 1 = lap
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      lvl;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      press_c;

   state_t            state_q;
   state_t            state_d;
   logic              run_d;
   logic              freeze_d;
   logic              clr_d;
   logic              tick_d;
   logic [TICK_W-1:0] tick_cnt;
   logic [TICK_W-1:0] tick_cnt_d;
   logic              ss_ev;
   logic              lap_ev;

   // Synchroniser and debouncer; the level flips after DB_CYCLES consecutive mismatches.
   always_ff @(posedge Clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         lvl   <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= {btn_lap, btn_ss};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != lvl[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  lvl[i]    <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Press event fires on the edge where the debounced level rises.
   always_comb begin
      press_c = '0;
      for (int i = 0; i < 2; i++)
         press_c[i] = sync2[i] & ~lvl[i] & (db_cnt[i] == DB_LAST);
   end

   assign ss_ev  = press_c[0];
   assign lap_ev = press_c[1] & ~press_c[0];

   // Next state, registered outputs and tick divider.
   always_comb begin
      state_d    = state_q;
      clr_d      = 1'b0;
      tick_d     = 1'b0;
      tick_cnt_d = tick_cnt;
      case (state_q)
         S_IDLE: begin
            if (ss_ev)       state_d = S_RUN;
            else if (lap_ev) clr_d   = 1'b1;
         end
         S_RUN: begin
            if (ss_ev)       state_d = S_PAUSE;
            else if (lap_ev) state_d = S_LAP;
         end
         S_LAP: begin
            if (ss_ev)       state_d = S_PAUSE;
            else if (lap_ev) state_d = S_RUN;
         end
         S_PAUSE: begin
            if (ss_ev) begin
               state_d = S_RUN;
            end else if (lap_ev) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      run_d    = (state_d == S_RUN) || (state_d == S_LAP);
      freeze_d = (state_d == S_LAP);
      // Only cycles that stay running advance, so a pause edge never ticks.
      if (clr_d) begin
         tick_cnt_d = '0;
      end else if (run && run_d) begin
         if (tick_cnt == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt + TICK_W'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         run      <= 1'b0;
         freeze   <= 1'b0;
         clr      <= 1'b0;
         tick     <= 1'b0;
         tick_cnt <= '0;
      end else begin
         state_q  <= state_d;
         run      <= run_d;
         freeze   <= freeze_d;
         clr      <= clr_d;
         tick     <= tick_d;
         tick_cnt <= tick_cnt_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner cases
// and random button activity against a behavioural model.
module tb_stopwatch_ctrl;

   localparam int DB = 4;
   localparam int TD = 10;
   localparam logic [1:0] NXT_SS  [4] = '{2'd1, 2'd3, 2'd3, 2'd1};
   localparam logic [1:0] NXT_LAP [4] = '{2'd0, 2'd2, 2'd1, 2'd0};

   logic       Clk;
   logic       rst;
   logic       btn_ss;
   logic       btn_lap;
   logic       run;
   logic       tick;
   logic       clr;
   logic       freeze;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   stopwatch_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
      .Clk(Clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
      .run(run), .tick(tick), .clr(clr), .freeze(freeze), .state(state)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural model: raw -> two-sample delay -> "last DB samples all differ" flip.
   logic [1:0] m_st;
   bit m_run, m_frz, m_clr, m_tick;
   int m_cnt;
   bit m_raw [2][2];
   bit m_sh  [2][DB];
   bit m_lvl [2];

   task automatic model_step(input bit r, input bit s, input bit l);
      bit raw [2];
      bit ev  [2];
      bit sync, all_diff, was_run;
      raw[0] = s;
      raw[1] = l;
      if (r) begin
         m_st = 2'd0; m_run = 0; m_frz = 0; m_clr = 0; m_tick = 0; m_cnt = 0;
         for (int b = 0; b < 2; b++) begin
            m_raw[b][0] = 0; m_raw[b][1] = 0; m_lvl[b] = 0;
            for (int i = 0; i < DB; i++) m_sh[b][i] = 0;
         end
         return;
      end
      for (int b = 0; b < 2; b++) begin
         sync = m_raw[b][1];
         m_raw[b][1] = m_raw[b][0];
         m_raw[b][0] = raw[b];
         for (int i = DB - 1; i > 0; i--) m_sh[b][i] = m_sh[b][i-1];
         m_sh[b][0] = sync;
         all_diff = 1;
         for (int i = 0; i < DB; i++) if (m_sh[b][i] == m_lvl[b]) all_diff = 0;
         ev[b] = 0;
         if (all_diff) begin
            m_lvl[b] = !m_lvl[b];
            ev[b]    = m_lvl[b];
         end
      end
      was_run = m_run;
      m_clr   = 0;
      if (ev[0]) begin
         m_st = NXT_SS[m_st];
      end else if (ev[1]) begin
         m_clr = (m_st == 2'd0) || (m_st == 2'd3);
         m_st  = NXT_LAP[m_st];
      end
      m_run  = (m_st == 2'd1) || (m_st == 2'd2);
      m_frz  = (m_st == 2'd2);
      m_tick = 0;
      if (m_clr) begin
         m_cnt = 0;
      end else if (was_run && m_run) begin
         m_cnt++;
         if (m_cnt == TD) begin
            m_cnt  = 0;
            m_tick = 1;
         end
      end
   endtask

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, step the model at the edge, compare at the falling edge.
   task automatic cyc(input bit r, input bit s, input bit l);
      rst = r; btn_ss = s; btn_lap = l;
      @(posedge Clk);
      model_step(r, s, l);
      @(negedge Clk);
      check("cycle_outputs", {2'b00, state, run, freeze, clr, tick},
            {2'b00, m_st, m_run, m_frz, m_clr, m_tick});
   endtask

   task automatic hold(input bit s, input bit l, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, s, l);
   endtask

   // Cycles (inputs released) until the next tick, bounded.
   task automatic cycles_to_tick(output int n);
      n = 0;
      do begin
         cyc(1'b0, 1'b0, 1'b0);
         n++;
      end while (tick !== 1'b1 && n < 40);
   endtask

   typedef struct {
      bit         r;
      bit         s;
      bit         l;
      int         n;
      logic [1:0] st;
      bit         rn;
      bit         fz;
   } vec_t;

   vec_t tbl [$];

   initial begin
      int ntick, first, last, badsp, n, nclr, seen_lap, seg;
      bit rs, rl;

      rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0;

      tbl.push_back('{1, 0, 0, 3,  2'd0, 0, 0});  // reset
      tbl.push_back('{0, 1, 0, 5,  2'd0, 0, 0});  // start not yet accepted
      tbl.push_back('{0, 1, 0, 1,  2'd1, 1, 0});  // accepted on 6th edge
      tbl.push_back('{0, 0, 0, 10, 2'd1, 1, 0});  // release: no event
      tbl.push_back('{0, 0, 1, 5,  2'd1, 1, 0});
      tbl.push_back('{0, 0, 1, 1,  2'd2, 1, 1});  // lap
      tbl.push_back('{0, 0, 0, 10, 2'd2, 1, 1});
      tbl.push_back('{0, 1, 0, 6,  2'd3, 0, 0});  // pause from lap
      tbl.push_back('{0, 0, 0, 10, 2'd3, 0, 0});
      tbl.push_back('{0, 0, 1, 5,  2'd3, 0, 0});
      tbl.push_back('{0, 0, 1, 1,  2'd0, 0, 0});  // clear to idle
      tbl.push_back('{0, 0, 0, 10, 2'd0, 0, 0});
      tbl.push_back('{0, 1, 0, 3,  2'd0, 0, 0});  // 3-cycle glitch
      tbl.push_back('{0, 0, 0, 10, 2'd0, 0, 0});
      tbl.push_back('{0, 1, 0, 1,  2'd0, 0, 0});  // bounce 1,0,1,0
      tbl.push_back('{0, 0, 0, 1,  2'd0, 0, 0});
      tbl.push_back('{0, 1, 0, 1,  2'd0, 0, 0});
      tbl.push_back('{0, 0, 0, 1,  2'd0, 0, 0});
      tbl.push_back('{0, 1, 0, 5,  2'd0, 0, 0});  // final rise held
      tbl.push_back('{0, 1, 0, 1,  2'd1, 1, 0});
      tbl.push_back('{0, 0, 0, 10, 2'd1, 1, 0});

      foreach (tbl[k]) begin
         for (int i = 0; i < tbl[k].n; i++) cyc(tbl[k].r, tbl[k].s, tbl[k].l);
         check($sformatf("table_%0d", k), {3'b000, state, run, freeze, 1'b0},
               {3'b000, tbl[k].st, tbl[k].rn, tbl[k].fz, 1'b0});
      end

      // Start and count: 100 running cycles give 10 evenly spaced ticks.
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      hold(1'b1, 1'b0, 6);
      check("start_state", {6'd0, state}, 8'd1);
      ntick = 0; first = -1; last = 0; badsp = 0;
      for (int i = 1; i <= 100; i++) begin
         cyc(1'b0, i <= 14, 1'b0);
         if (tick === 1'b1) begin
            if (first < 0) first = i;
            else if (i - last != TD) badsp++;
            last = i;
            ntick++;
         end
      end
      check("tick_count", 8'(ntick), 8'd10);
      check("first_tick", 8'(first), 8'd10);
      check("tick_spacing", 8'(badsp), 8'd0);

      // Pause after 7 running cycles, hold 50, resume: tick after 3 more.
      hold(1'b0, 1'b0, 2);
      hold(1'b1, 1'b0, 6);
      check("pause_state", {6'd0, state}, 8'd3);
      ntick = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (tick === 1'b1) ntick++;
      end
      check("pause_no_tick", 8'(ntick), 8'd0);
      hold(1'b1, 1'b0, 6);
      check("resume_state", {6'd0, state}, 8'd1);
      cycles_to_tick(n);
      check("resume_first_tick", 8'(n), 8'd3);

      // Lap, pause, clear.
      hold(1'b0, 1'b0, 8);
      hold(1'b0, 1'b1, 6);
      check("lap_outputs", {5'd0, state, freeze}, {5'd0, 2'd2, 1'b1});
      check("lap_run", {7'd0, run}, 8'd1);
      hold(1'b0, 1'b0, 8);
      hold(1'b1, 1'b0, 6);
      check("lap_to_pause", {5'd0, state, freeze}, {5'd0, 2'd3, 1'b0});
      hold(1'b0, 1'b0, 8);
      nclr = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(1'b0, 1'b0, i < 6);
         if (clr === 1'b1) nclr++;
         if (i == 5) check("clear_state", {6'd0, state}, 8'd0);
         if (i == 5) check("clear_with_state", {7'd0, clr}, 8'd1);
      end
      check("clr_width", 8'(nclr), 8'd1);
      hold(1'b1, 1'b0, 6);
      cycles_to_tick(n);
      check("divider_cleared", 8'(n), 8'd10);

      // Simultaneous presses in RUN: start/stop wins.
      hold(1'b0, 1'b0, 8);
      nclr = 0; seen_lap = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, 1'b1);
         if (clr === 1'b1) nclr++;
         if (state === 2'd2) seen_lap++;
      end
      check("simul_state", {6'd0, state}, 8'd3);
      check("simul_no_lap_no_clr", 8'(nclr + seen_lap), 8'd0);
      hold(1'b0, 1'b0, 8);

      // Reset in the middle of LAP.
      hold(1'b1, 1'b0, 6);
      hold(1'b0, 1'b0, 8);
      hold(1'b0, 1'b1, 6);
      check("pre_reset_lap", {6'd0, state}, 8'd2);
      hold(1'b0, 1'b1, 13);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 0);
         check("reset_outputs", {2'b00, state, run, freeze, clr, tick}, 8'd0);
      end
      hold(1'b0, 1'b0, 10);

      // Random button activity against the model.
      seg = 0;
      while (seg < 250) begin
         rs = ($urandom_range(0, 2) == 0);
         rl = ($urandom_range(0, 2) == 0);
         n  = $urandom_range(1, 12);
         if ($urandom_range(0, 60) == 0) begin
            for (int i = 0; i < $urandom_range(1, 3); i++) cyc(1'b1, rs, rl);
         end else begin
            hold(rs, rl, n);
         end
         seg++;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven sequencer for the `stop_watch` time counter.
- Synchronises and debounces two raw push-buttons.
- Runs a Run/Pause/Lap/Idle state machine.
- Produces the gated one-second count enable, the one-cycle clear pulse and the display-freeze level that drive the counter and its display path.
- Sits between the board buttons and `stop_watch` in the timer top level.

## Interface

Parameters:
- `DB_CYCLES`, 20: consecutive stable samples needed to accept a button level change (≥2).
- `TICK_DIV`, 100: Clk cycles per count tick (≥2); the board build sets it to the clock frequency in Hz.

Ports:
- `Clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_ss` input 1: raw start/stop button, asynchronous, active-high.
- `btn_lap` input 1: raw lap/reset button, asynchronous, active-high.
- `run` output 1: counting enabled (level).
- `tick` output 1: one-cycle count-enable pulse, one per `TICK_DIV` running cycles.
- `clr` output 1: one-cycle pulse that zeroes the time counter.
- `freeze` output 1: display hold level; the display path latches the time while it is high.
- `state` output 2: current state, encoded IDLE=00, RUN=01, LAP=10, PAUSE=11.

## Operation

- **Synchroniser:** each button passes through a 2-flop synchroniser.
- **Debouncer, one per button:**
  - A counter increments on each cycle where the synchronised level differs from the debounced level.
  - It clears on any matching cycle.
  - On the edge that completes `DB_CYCLES` consecutive mismatches, the debounced level takes the new value and the counter clears.
  - A 0→1 debounced transition produces an internal one-cycle press event. Releases produce no event.
- **Simultaneous presses:** if both press events occur in the same cycle, the `btn_ss` event wins and the `btn_lap` event is discarded.
- **FSM, all outputs registered:**
  - IDLE: `run`=0, `freeze`=0.
    - ss press → RUN.
    - lap press → stay in IDLE, pulse `clr`.
  - RUN: `run`=1, `freeze`=0.
    - ss press → PAUSE.
    - lap press → LAP.
  - LAP: `run`=1, `freeze`=1; counting continues while the display holds.
    - lap press → RUN (display releases).
    - ss press → PAUSE.
  - PAUSE: `run`=0, `freeze`=0.
    - ss press → RUN.
    - lap press → IDLE and pulse `clr`.
- **Tick divider:**
  - Counter runs 0..`TICK_DIV`-1 and advances only while `run`=1.
  - `tick`=1 for exactly the cycle in which the counter wraps from `TICK_DIV`-1 to 0 while `run`=1.
  - The counter holds its value in PAUSE, so the partial second is preserved.
  - The counter clears to 0 on the edge that asserts `clr`.
  - Width is clog2(`TICK_DIV`); no other wrap.
- **Reset:** `rst` has priority over all events.

## Timing

- **Reset values:** after any edge with `rst`=1:
  - State IDLE; `run`=0, `tick`=0, `clr`=0, `freeze`=0, `state`=00.
  - Synchronisers, debounced levels, debounce counters and tick divider are all 0.
- **Mid-operation reset:** identical result. No `clr` pulse is emitted for the reset itself.
- **Press latency:** a raw button held high from edge k changes `state`/`run`/`freeze`/`clr` at edge k+2+`DB_CYCLES` (2 synchroniser + `DB_CYCLES` debounce); outputs are visible after that edge.
- **Glitch rejection:** any raw pulse or bounce shorter than `DB_CYCLES` cycles produces no event.
- **Clear pulse:** `clr` is high for exactly one cycle, in the same cycle the new state is first visible.
- **First tick after entering RUN from IDLE:** the counter runs 0..`TICK_DIV`-1, so `tick` occurs at the edge where the counter wraps `TICK_DIV`-1→0.
- **Pause at edge p:** `tick` never fires from edge p onward until RUN is re-entered.
- **Held button:** a continuously held button generates one event only; a new event needs a debounced release then a press.

## Test plan

- **Reset:** `DB_CYCLES`=4, `TICK_DIV`=10. Assert `rst` 3 cycles mid-count in LAP → next edge all outputs 0, `state`=00, no `clr`.
- **Start and count:** press `btn_ss` 20 cycles from IDLE → `run`=1, `state`=01 exactly 6 edges after the raw rise; 100 running cycles yield exactly 10 `tick` pulses spaced 10 cycles apart.
- **Bounce:** raw `btn_ss` toggles 1,0,1,0 at 1-cycle intervals then holds 1 → exactly one transition, occurring 6 edges after the final rise; a 3-cycle glitch alone → no transition.
- **Pause/resume:** pause after 7 running cycles, idle 50 cycles, resume → first `tick` arrives after 3 more running cycles; no `tick` while `state`=11.
- **Lap and clear:**
  - RUN, lap press → `freeze`=1, `run`=1, `state`=10.
  - ss press → `state`=11, `freeze`=0.
  - lap press → `state`=00, single-cycle `clr`, divider back at 0.
- **Simultaneous press:** `btn_ss` and `btn_lap` rise on the same edge in RUN → `state`=11 (PAUSE), no LAP, no `clr`.
